// File: rtl/adc_align_ctrl.sv
// adc_align_ctrl: post-reset word-alignment sequencer for the per-lane 1:8 DDR
// deserializers of the ADC capture path. Walks lanes in order, issues bitslip
// pulses until the training pattern holds, and reports per-lane status.
// Optional build macro: ADC_ALIGN_TIMEOUT_EN adds a 24-bit WAIT_RDY watchdog.
module adc_align_ctrl #(
  parameter int unsigned  S             = 8,
  parameter int unsigned  D             = 16,
  parameter logic [D-1:0] TRAIN_PATTERN = 16'hA5C3,
  parameter int unsigned  MATCH_CNT     = 8,
  parameter int unsigned  MAX_SLIPS     = 8,
  parameter int unsigned  SETTLE_CYC    = 4
) (
  input  logic           ref_clk,
  input  logic           ref_rst_n,
  input  logic           start,
  input  logic           delay_ready,
  input  logic [S-1:0]   rx_locked,
  input  logic [S*D-1:0] rx_data,
  output logic [S-1:0]   bitslip,
  output logic [S*4-1:0] bcount,
  output logic [S-1:0]   lane_aligned,
  output logic [S-1:0]   lane_fail,
  output logic           align_done,
  output logic           align_ok,
  output logic           busy
);

  localparam int unsigned LW = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned CW = 8;
  localparam int unsigned BW = 4;

  localparam logic [LW-1:0] LAST_LANE  = LW'(S - 1);
  localparam logic [CW-1:0] MATCH_TGT  = CW'(MATCH_CNT);
  localparam logic [CW-1:0] SETTLE_TGT = CW'(SETTLE_CYC);
  localparam logic [BW-1:0] SLIP_MAX   = BW'(MAX_SLIPS);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, CHECK, SLIP, SETTLE, NEXT, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [CW-1:0]   match_q, match_d;
  logic [CW-1:0]   settle_q, settle_d;
  logic [S-1:0]    bitslip_d;
  logic [S*BW-1:0] bcount_d;
  logic [S-1:0]    aligned_d;
  logic [S-1:0]    fail_d;
  logic            done_d;
  logic            ok_d;
  logic            busy_d;

  logic            lock_ok;
  logic            hold_done;
  logic [D-1:0]    cur_word;
  logic [BW-1:0]   cur_bcnt;

`ifdef ADC_ALIGN_TIMEOUT_EN
  localparam int unsigned WW = 24;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            tout_q, tout_d;
`endif

  // Readiness of the whole capture front end
  assign lock_ok = delay_ready & (&rx_locked);

  // Select the word and slip count of the lane currently being aligned
  always_comb begin
    cur_word = '0;
    cur_bcnt = '0;
    for (int unsigned i = 0; i < S; i++) begin
      if (lane_q == LW'(i)) begin
        cur_word = rx_data[i*D +: D];
        cur_bcnt = bcount[i*BW +: BW];
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge ref_clk or negedge ref_rst_n) begin
    if (!ref_rst_n) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      match_q      <= '0;
      settle_q     <= '0;
      bitslip      <= '0;
      bcount       <= '0;
      lane_aligned <= '0;
      lane_fail    <= '0;
      align_done   <= 1'b0;
      align_ok     <= 1'b0;
      busy         <= 1'b0;
`ifdef ADC_ALIGN_TIMEOUT_EN
      wdog_q       <= '0;
      tout_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      match_q      <= match_d;
      settle_q     <= settle_d;
      bitslip      <= bitslip_d;
      bcount       <= bcount_d;
      lane_aligned <= aligned_d;
      lane_fail    <= fail_d;
      align_done   <= done_d;
      align_ok     <= ok_d;
      busy         <= busy_d;
`ifdef ADC_ALIGN_TIMEOUT_EN
      wdog_q       <= wdog_d;
      tout_q       <= tout_d;
`endif
    end
  end

  // Next-state and next-output logic; lock loss is applied last so it wins
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    match_d   = match_q;
    settle_d  = settle_q;
    bitslip_d = '0;
    bcount_d  = bcount;
    aligned_d = lane_aligned;
    fail_d    = lane_fail;
    done_d    = align_done;
    ok_d      = align_ok;
    hold_done = 1'b0;
`ifdef ADC_ALIGN_TIMEOUT_EN
    wdog_d    = wdog_q;
    tout_d    = tout_q;
    hold_done = tout_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          aligned_d = '0;
          fail_d    = '0;
          bcount_d  = '0;
          state_d   = WAIT_RDY;
        end
      end

      WAIT_RDY: begin
        if (lock_ok) begin
          lane_d  = '0;
          match_d = '0;
          state_d = CHECK;
        end
`ifdef ADC_ALIGN_TIMEOUT_EN
        else if (wdog_q == '1) begin
          fail_d  = '1;
          done_d  = 1'b1;
          ok_d    = 1'b0;
          tout_d  = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
`endif
      end

      CHECK: begin
        if (cur_word == TRAIN_PATTERN) begin
          if ((match_q + CW'(1)) == MATCH_TGT) begin
            match_d           = '0;
            aligned_d[lane_q] = 1'b1;
            state_d           = NEXT;
          end else begin
            match_d = match_q + CW'(1);
          end
        end else begin
          match_d = '0;
          if (cur_bcnt == SLIP_MAX) begin
            fail_d[lane_q] = 1'b1;
            state_d        = NEXT;
          end else begin
            bitslip_d[lane_q] = 1'b1;
            state_d           = SLIP;
          end
        end
      end

      SLIP: begin
        for (int unsigned i = 0; i < S; i++) begin
          if (lane_q == LW'(i) && cur_bcnt != SLIP_MAX) begin
            bcount_d[i*BW +: BW] = cur_bcnt + BW'(1);
          end
        end
        settle_d = '0;
        state_d  = SETTLE;
      end

      SETTLE: begin
        if ((settle_q + CW'(1)) == SETTLE_TGT) begin
          settle_d = '0;
          match_d  = '0;
          state_d  = CHECK;
        end else begin
          settle_d = settle_q + CW'(1);
        end
      end

      NEXT: begin
        match_d = '0;
        if (lane_q == LAST_LANE) begin
          done_d  = 1'b1;
          ok_d    = &lane_aligned;
          state_d = DONE;
        end else begin
          lane_d  = lane_q + LW'(1);
          state_d = CHECK;
        end
      end

      DONE: begin
        done_d = 1'b1;
        ok_d   = &lane_aligned;
        if (start) begin
          aligned_d = '0;
          fail_d    = '0;
          bcount_d  = '0;
          done_d    = 1'b0;
          ok_d      = 1'b0;
`ifdef ADC_ALIGN_TIMEOUT_EN
          tout_d    = 1'b0;
`endif
          state_d   = WAIT_RDY;
        end
      end

      default: state_d = IDLE;
    endcase

    // Lock loss restarts the sequence; a watchdog-forced DONE is held until start
    if (state_q != IDLE && state_q != WAIT_RDY && !lock_ok && !hold_done) begin
      state_d   = WAIT_RDY;
      lane_d    = '0;
      match_d   = '0;
      settle_d  = '0;
      bitslip_d = '0;
      bcount_d  = '0;
      aligned_d = '0;
      fail_d    = '0;
      done_d    = 1'b0;
      ok_d      = 1'b0;
    end

`ifdef ADC_ALIGN_TIMEOUT_EN
    // Watchdog restarts on every entry into WAIT_RDY
    if (state_d == WAIT_RDY && state_q != WAIT_RDY) begin
      wdog_d = '0;
    end
`endif

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

endmodule

// File: tb/tb_adc_align_ctrl.sv
// tb_adc_align_ctrl: randomized self-checking bench for adc_align_ctrl.
// Each lane is modelled as a deserializer that presents the training word only
// after a chosen number of bitslips; results are predicted from that number.
module tb_adc_align_ctrl;

  localparam int unsigned S          = 8;
  localparam int unsigned D          = 16;
  localparam int unsigned MATCH_CNT  = 8;
  localparam int unsigned MAX_SLIPS  = 8;
  localparam int unsigned SETTLE_CYC = 4;
  localparam logic [D-1:0] PAT       = 16'hA5C3;
  localparam int           NEVER     = 99;
  localparam int           BUDGET    = 3000;

  logic           ref_clk = 1'b0;
  logic           ref_rst_n;
  logic           start;
  logic           delay_ready;
  logic [S-1:0]   rx_locked;
  logic [S*D-1:0] rx_data;
  logic [S-1:0]   bitslip;
  logic [S*4-1:0] bcount;
  logic [S-1:0]   lane_aligned;
  logic [S-1:0]   lane_fail;
  logic           align_done;
  logic           align_ok;
  logic           busy;

  adc_align_ctrl #(
    .S(S), .D(D), .TRAIN_PATTERN(PAT), .MATCH_CNT(MATCH_CNT),
    .MAX_SLIPS(MAX_SLIPS), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .ref_clk(ref_clk), .ref_rst_n(ref_rst_n), .start(start),
    .delay_ready(delay_ready), .rx_locked(rx_locked), .rx_data(rx_data),
    .bitslip(bitslip), .bcount(bcount), .lane_aligned(lane_aligned),
    .lane_fail(lane_fail), .align_done(align_done), .align_ok(align_ok),
    .busy(busy)
  );

  always #5 ref_clk = ~ref_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int need[S];    // slips each lane model requires before it shows PAT
  int seen[S];    // slips the lane model has received
  int want[S];    // slips still required when the current pass begins
  int pulses[S];
  int cyc        = 0;
  int last_pulse = -1000;
  int first_lane = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [D-1:0] rotl(input logic [D-1:0] w, input int r);
    logic [2*D-1:0] x;
    x = {w, w} << r;
    return x[2*D-1 -: D];
  endfunction

  // Deserializer model: rotated word until enough slips have arrived
  task automatic drive_rx();
    for (int i = 0; i < S; i++) begin
      if (seen[i] >= need[i]) rx_data[i*D +: D] = PAT;
      else rx_data[i*D +: D] = rotl(PAT, ((need[i] - seen[i] - 1) % 15) + 1);
    end
  endtask

  // Advance one cycle, sample at the falling edge and react to slip pulses
  task automatic step();
    @(negedge ref_clk);
    cyc++;
    if (bitslip != '0) begin
      check_eq("slip_onehot", 64'($countones(bitslip)), 64'd1);
      check_eq("slip_spacing_ok", 64'((cyc - last_pulse) >= int'(SETTLE_CYC + 2)), 64'd1);
      last_pulse = cyc;
      for (int i = 0; i < S; i++) begin
        if (bitslip[i]) begin
          seen[i]++;
          pulses[i]++;
          if (first_lane < 0) first_lane = i;
        end
      end
      drive_rx();
    end
  endtask

  task automatic clear_monitor();
    for (int i = 0; i < S; i++) pulses[i] = 0;
    last_pulse = -1000;
    first_lane = -1;
  endtask

  // Wait for completion (exit from WAIT_RDY is the first step) and check results
  task automatic wait_and_check(input bit busy_start);
    int n;
    int t;
    int exp_first;
    logic [S-1:0]   ea;
    logic [S-1:0]   ef;
    logic [S*4-1:0] eb;
    n = 0;
    while (!align_done && n < BUDGET) begin
      start = busy_start && (n == 4 || n == 19 || n == 37);
      step();
      start = 1'b0;
      n++;
      if (n == 10) check_eq("busy_mid", 64'(busy), 64'd1);
    end
    if (n >= BUDGET) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      return;
    end
    t = 0;
    ea = '0;
    ef = '0;
    eb = '0;
    exp_first = -1;
    for (int i = 0; i < S; i++) begin
      if (want[i] > 0 && exp_first < 0) exp_first = i;
      if (want[i] <= int'(MAX_SLIPS)) begin
        t += int'(SETTLE_CYC + 2) * want[i] + int'(MATCH_CNT) + 1;
        ea[i] = 1'b1;
        eb[i*4 +: 4] = 4'(want[i]);
      end else begin
        t += int'(SETTLE_CYC + 2) * int'(MAX_SLIPS) + 2;
        ef[i] = 1'b1;
        eb[i*4 +: 4] = 4'(MAX_SLIPS);
      end
    end
    check_eq("done_latency", 64'(n), 64'(t + 1));
    check_eq("lane_aligned", 64'(lane_aligned), 64'(ea));
    check_eq("lane_fail", 64'(lane_fail), 64'(ef));
    check_eq("bcount", 64'(bcount), 64'(eb));
    check_eq("align_ok", 64'(align_ok), 64'(ef == '0));
    check_eq("busy_done", 64'(busy), 64'd0);
    check_eq("first_slip_lane", 64'(first_lane), 64'(exp_first));
    for (int i = 0; i < S; i++) begin
      check_eq($sformatf("pulses_lane%0d", i), 64'(pulses[i]),
               64'((want[i] <= int'(MAX_SLIPS)) ? want[i] : int'(MAX_SLIPS)));
    end
    step();
    check_eq("done_hold", 64'(align_done), 64'd1);
    check_eq("bitslip_idle", 64'(bitslip), 64'd0);
  endtask

  task automatic run_pass(input bit busy_start);
    for (int i = 0; i < S; i++) begin
      seen[i] = 0;
      want[i] = need[i];
    end
    clear_monitor();
    drive_rx();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_and_check(busy_start);
  endtask

  // Drop lane 2 lock while lane 4 settles after its first slip, then relock
  task automatic lock_loss_pass();
    int n;
    need = '{1, 1, 1, 1, 3, 0, 0, 0};
    for (int i = 0; i < S; i++) seen[i] = 0;
    clear_monitor();
    drive_rx();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!bitslip[4] && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) begin
      check_eq("lane4_slip_timeout", 64'd0, 64'd1);
      return;
    end
    step();
    rx_locked[2] = 1'b0;
    step();
    check_eq("ll_aligned", 64'(lane_aligned), 64'd0);
    check_eq("ll_fail", 64'(lane_fail), 64'd0);
    check_eq("ll_bcount", 64'(bcount), 64'd0);
    check_eq("ll_done", 64'(align_done), 64'd0);
    check_eq("ll_ok", 64'(align_ok), 64'd0);
    check_eq("ll_bitslip", 64'(bitslip), 64'd0);
    check_eq("ll_busy", 64'(busy), 64'd1);
    rx_locked = '1;
    // Lanes 0-3 and one slip of lane 4 were already applied before the drop
    want = '{0, 0, 0, 0, 2, 0, 0, 0};
    clear_monitor();
    wait_and_check(1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_bitslip"}, 64'(bitslip), 64'd0);
    check_eq({tag, "_bcount"}, 64'(bcount), 64'd0);
    check_eq({tag, "_aligned"}, 64'(lane_aligned), 64'd0);
    check_eq({tag, "_fail"}, 64'(lane_fail), 64'd0);
    check_eq({tag, "_done"}, 64'(align_done), 64'd0);
    check_eq({tag, "_ok"}, 64'(align_ok), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    ref_rst_n   = 1'b0;
    start       = 1'b0;
    delay_ready = 1'b1;
    rx_locked   = '1;
    for (int i = 0; i < S; i++) begin
      need[i] = 0;
      seen[i] = 0;
    end
    drive_rx();
    repeat (3) @(negedge ref_clk);
    check_reset_outputs("reset");
    ref_rst_n = 1'b1;
    step();
    step();
    check_eq("idle_busy", 64'(busy), 64'd0);

    // Pattern already aligned
    need = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_pass(1'b0);
    // Lane 3 needs three slips
    need = '{0, 0, 0, 3, 0, 0, 0, 0};
    run_pass(1'b0);
    // Lane 5 never matches
    need = '{0, 0, 0, 0, 0, NEVER, 0, 0};
    run_pass(1'b0);
    // Lane 0 matches on the last permitted slip
    need = '{8, 0, 0, 0, 0, 0, 0, 0};
    run_pass(1'b0);
    // start pulses while busy are ignored
    need = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_pass(1'b1);
    // Lock loss mid-sequence
    lock_loss_pass();

    // Randomized slip requirements
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < S; i++) begin
        int v;
        v = int'($urandom_range(0, 10));
        need[i] = (v <= 5) ? (v % 3) : ((v <= 8) ? v : NEVER);
      end
      run_pass(1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a pass
    need = '{2, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < S; i++) seen[i] = 0;
    clear_monitor();
    drive_rx();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    ref_rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge ref_clk);
    ref_rst_n = 1'b1;
    step();
    check_eq("post_reset_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
